// File: rtl/decode_execute_seq_pkg.sv
// Shared definitions for the decode/execute sequencer: opcodes, FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package decode_execute_pkg;

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // SRA and ROL are the only opcodes that execute serially.
  function automatic logic is_shift_op(input logic [2:0] sel);
    return sel[2:1] == 2'b10;
  endfunction

endpackage

// File: rtl/decode_execute_seq_if.sv
// Request/result bus of the decode/execute sequencer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: request in_valid/in_ready/sel/rs/rt/shamt; result out_valid/out_ready/rd/zero/carry.
interface decode_execute_seq_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       sel;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rd;
  logic             zero;
  logic             carry;

  // Requester / result consumer side.
  modport master (
    output in_valid, sel, rs, rt, shamt, out_ready,
    input  in_ready, out_valid, rd, zero, carry
  );

  // Execution unit side.
  modport slave (
    input  in_valid, sel, rs, rt, shamt, out_ready,
    output in_ready, out_valid, rd, zero, carry
  );
endinterface

// File: rtl/decode_execute_seq_alu_core.sv
// Combinational ALU: single-shot SUB/ADD/OR/AND/LT/EQ plus one-bit SRA/ROL steps.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when results are captured.
// Ports: sel_i/a_i/b_i -> res_o/carry_o; step_i -> sra_o/sra_c_o, rol_o/rol_c_o.
module dae_alu_core
  import decode_execute_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  input  logic [WIDTH-1:0] step_i,
  output logic [WIDTH-1:0] sra_o,
  output logic             sra_c_o,
  output logic [WIDTH-1:0] rol_o,
  output logic             rol_c_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    sum     = '0;
    case (sel_i)
      OP_SUB: begin
        // a + ~b + 1: the carry out is the no-borrow flag (a >= b).
        sum     = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
        res_o   = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
      end
      OP_ADD: begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        res_o   = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
      end
      OP_OR:  res_o = a_i | b_i;
      OP_AND: res_o = a_i & b_i;
      // Shift ops reaching here have a zero amount: pass the operand through.
      OP_SRA: res_o = b_i;
      OP_ROL: res_o = a_i;
      OP_LT:  res_o = WIDTH'(a_i < b_i);
      OP_EQ:  res_o = WIDTH'(a_i == b_i);
      default: ;
    endcase
  end

  assign sra_o   = {step_i[WIDTH-1], step_i[WIDTH-1:1]};
  assign sra_c_o = step_i[0];
  assign rol_o   = {step_i[WIDTH-2:0], step_i[WIDTH-1]};
  assign rol_c_o = step_i[WIDTH-1];

endmodule

// File: rtl/decode_execute_seq.sv
// Registered decode/execute unit: one op per handshake, serial SRA/ROL, zero/carry flags.
// Latency: 1 cycle for single-shot ops and zero shifts, shamt+1 cycles for shifts.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
// Ports: clk, rst_n (async, active-low), bus (decode_execute_seq_if.slave).
module decode_execute_seq
  import decode_execute_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decode_execute_seq_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] rd_q;     // doubles as the shift working register
  logic             carry_q;
  logic [SHW-1:0]   cnt_q;
  logic             rol_q;    // 1: rotating left, 0: arithmetic right shift

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH-1:0] sra_step;
  logic             sra_c;
  logic [WIDTH-1:0] rol_step;
  logic             rol_c;

  dae_alu_core #(.WIDTH(WIDTH)) u_alu (
    .sel_i   (bus.sel),
    .a_i     (bus.rs),
    .b_i     (bus.rt),
    .res_o   (alu_res),
    .carry_o (alu_c),
    .step_i  (rd_q),
    .sra_o   (sra_step),
    .sra_c_o (sra_c),
    .rol_o   (rol_step),
    .rol_c_o (rol_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      rol_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (is_shift_op(bus.sel) && (bus.shamt != '0)) begin
              rd_q    <= bus.sel[0] ? bus.rs : bus.rt;
              rol_q   <= bus.sel[0];
              carry_q <= 1'b0;
              cnt_q   <= bus.shamt;
              state_q <= ST_SHIFT;
            end else begin
              rd_q    <= alu_res;
              carry_q <= alu_c;
              state_q <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (rol_q) begin
            rd_q    <= rol_step;
            carry_q <= rol_c;
          end else begin
            rd_q    <= sra_step;
            carry_q <= sra_c;
          end
          cnt_q <= cnt_q - SHW'(1);
          // The edge performing the last step also enters DONE.
          if (cnt_q == SHW'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.rd        = rd_q;
  assign bus.zero      = (rd_q == '0);
  assign bus.carry     = carry_q;

endmodule

// File: tb/tb_decode_execute_seq.sv
// Directed bench for decode_execute_seq at WIDTH=8.
// Latency: n/a.
// Backpressure: exercises held results with out_ready low.
module tb_decode_execute_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  decode_execute_seq_if #(.WIDTH(8)) bus ();

  decode_execute_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs after acceptance, wait for the
  // result, check it and its latency, then consume it.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] sh, input logic [7:0] erd,
                        input logic ec, input int elat);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.sel      = sel;
    bus.rs       = a;
    bus.rt       = b;
    bus.shamt    = sh;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.sel      = ~sel;
    bus.rs       = ~a;
    bus.rt       = ~b;
    bus.shamt    = ~sh;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " rd"}, 32'(bus.rd), 32'(erd));
    chk({tag, " carry"}, 32'(bus.carry), 32'(ec));
    chk({tag, " zero"}, 32'(bus.zero), 32'(erd == 8'h00));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, " back to idle"}, 32'(bus.in_ready), 32'd1);
    chk({tag, " out_valid dropped"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sel       = 3'b000;
    bus.rs        = 8'h00;
    bus.rt        = 8'h00;
    bus.shamt     = 3'd0;
    bus.out_ready = 1'b0;

    #12;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset rd", 32'(bus.rd), 32'h00);
    chk("reset zero", 32'(bus.zero), 32'd1);
    chk("reset carry", 32'(bus.carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("ADD F0+20", 3'b001, 8'hF0, 8'h20, 3'd0, 8'h10, 1'b1, 1);
    run_op("ADD FF+01", 3'b001, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1);
    run_op("SUB 05-07", 3'b000, 8'h05, 8'h07, 3'd0, 8'hFE, 1'b0, 1);
    run_op("SUB 07-07", 3'b000, 8'h07, 8'h07, 3'd0, 8'h00, 1'b1, 1);
    run_op("OR A5|0F", 3'b010, 8'hA5, 8'h0F, 3'd0, 8'hAF, 1'b0, 1);
    run_op("AND A5&0F", 3'b011, 8'hA5, 8'h0F, 3'd0, 8'h05, 1'b0, 1);
    run_op("SRA 90>>3", 3'b100, 8'h33, 8'h90, 3'd3, 8'hF2, 1'b0, 4);
    run_op("SRA 41>>1", 3'b100, 8'h00, 8'h41, 3'd1, 8'h20, 1'b1, 2);
    run_op("SRA 90>>0", 3'b100, 8'h00, 8'h90, 3'd0, 8'h90, 1'b0, 1);
    run_op("ROL 81<<1", 3'b101, 8'h81, 8'h55, 3'd1, 8'h03, 1'b1, 2);
    run_op("ROL 81<<7", 3'b101, 8'h81, 8'h00, 3'd7, 8'hC0, 1'b0, 8);
    run_op("ROL 81<<0", 3'b101, 8'h81, 8'h00, 3'd0, 8'h81, 1'b0, 1);
    run_op("LT 03<80", 3'b110, 8'h03, 8'h80, 3'd0, 8'h01, 1'b0, 1);
    run_op("LT 80<03", 3'b110, 8'h80, 8'h03, 3'd0, 8'h00, 1'b0, 1);
    run_op("EQ 5A==5A", 3'b111, 8'h5A, 8'h5A, 3'd0, 8'h01, 1'b0, 1);
    run_op("EQ 5A==5B", 3'b111, 8'h5A, 8'h5B, 3'd0, 8'h00, 1'b0, 1);

    // Reset in the middle of a rotate.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sel      = 3'b101;
    bus.rs       = 8'h81;
    bus.rt       = 8'h00;
    bus.shamt    = 3'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid-shift in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid-shift out_valid", 32'(bus.out_valid), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("async reset rd", 32'(bus.rd), 32'h00);
    chk("async reset zero", 32'(bus.zero), 32'd1);
    chk("async reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("async reset carry", 32'(bus.carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post-reset ADD 12+34", 3'b001, 8'h12, 8'h34, 3'd0, 8'h46, 1'b0, 1);

    // Consumer backpressure with a persistent, changing requester.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sel      = 3'b001;
    bus.rs       = 8'h12;
    bus.rt       = 8'h34;
    bus.shamt    = 3'd0;
    @(posedge clk);
    #1;
    chk("bp first result valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.sel      = 3'(i);
      bus.rs       = 8'($urandom);
      bus.rt       = 8'($urandom);
      bus.shamt    = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      chk("bp rd held", 32'(bus.rd), 32'h46);
      chk("bp in_ready low", 32'(bus.in_ready), 32'd0);
      chk("bp out_valid held", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp release rd", 32'(bus.rd), 32'h46);
    run_op("after bp EQ 5A==5A", 3'b111, 8'h5A, 8'h5A, 3'd0, 8'h01, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
